right_shift_register: RTL and testbench

// - Parallel-load, arithmetic right-shift register, one bit per enabled clock.
// - Holds the multiplier/partial-product word in the Robertson's (signed,
//   two's-complement) multiplier datapath; the controller loads the operand,

---
 rtl/right_shift_register_if.sv | 27 ++
 rtl/right_shift_register.sv | 42 ++++
 tb/tb_right_shift_register.sv | 128 ++++++++++++
 3 files changed

// File: rtl/right_shift_register_if.sv
// Operand bus of the shift register: enable/mode/load data in, register contents out.
// Latency: none (the bundle only groups the wires).
// Backpressure: none; the register accepts an operation on every enabled edge.
interface right_shift_register_if #(
    parameter int WIDTH = 16
);
    logic             enable;
    logic             mode;
    logic [WIDTH-1:0] in;
    logic [WIDTH-1:0] out;

    // Controller side: it drives the operation and observes the register.
    modport master (
        output enable,
        output mode,
        output in,
        input  out
    );

    // Register side: it consumes the operation and presents its contents.
    modport slave (
        input  enable,
        input  mode,
        input  in,
        output out
    );
endinterface

// File: rtl/right_shift_register.sv
// Parallel-load / arithmetic-right-shift register for the signed multiplier datapath.
// Latency: a load or shift appears on out one cycle after the enabling edge.
// Backpressure: none; enable=0 simply holds the current contents.
module right_shift_register #(
    parameter int WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    right_shift_register_if.slave bus
);

    // The initializer gives a known zero contents before the first reset.
    logic [WIDTH-1:0] r_q = '0;
    logic [WIDTH-1:0] r_d;

    // Next-state select. Enable is checked before mode so an unknown mode while
    // idle can never reach the register.
    always_comb begin
        r_d = r_q;
        if (bus.enable) begin
            if (bus.mode) begin
                r_d = bus.in;
            end else begin
                // Sign-preserving shift; the LSB falls off the end.
                r_d = {r_q[WIDTH-1], r_q[WIDTH-1:1]};
            end
        end
    end

    // Register update; synchronous reset overrides any requested operation.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= '0;
        end else begin
            r_q <= r_d;
        end
    end

    // Output comes straight from the flops, no combinational path from inputs.
    assign bus.out = r_q;

endmodule

// File: tb/tb_right_shift_register.sv
module tb_right_shift_register;

    localparam int WIDTH = 16;

    logic clk;
    logic reset;

    right_shift_register_if #(.WIDTH(WIDTH)) bus ();

    right_shift_register #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] exp;
        string            name;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp;
    int   n_bad;

    // Issue one edge worth of inputs and queue the value out must show after it.
    task automatic step(input logic rst, input logic en, input logic md,
                        input logic [WIDTH-1:0] din, input logic [WIDTH-1:0] exp,
                        input string name);
        exp_t e;
        reset      = rst;
        bus.enable = en;
        bus.mode   = md;
        bus.in     = din;
        e.exp      = exp;
        e.name     = name;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    // Monitor: the register presents a new value every edge; check it just after.
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (bus.out !== e.exp) begin
                    n_bad++;
                    $display("FAIL %s: out=%h expected=%h", e.name, bus.out, e.exp);
                end
            end
        end
    end

    logic [WIDTH-1:0] sat_tab [15];

    initial begin : stimulus
        int waited;
        n_cmp = 0;
        n_bad = 0;
        sat_tab = '{16'hC000, 16'hE000, 16'hF000, 16'hF800, 16'hFC00,
                    16'hFE00, 16'hFF00, 16'hFF80, 16'hFFC0, 16'hFFE0,
                    16'hFFF0, 16'hFFF8, 16'hFFFC, 16'hFFFE, 16'hFFFF};

        // Power-up contents are zero, idle edge keeps them.
        step(1'b0, 1'b0, 1'b0, 16'h1234, 16'h0000, "powerup");

        // Reset then hold with load data presented but enable low.
        step(1'b1, 1'b0, 1'b1, 16'h9696, 16'h0000, "reset");
        for (int i = 0; i < 5; i++)
            step(1'b0, 1'b0, 1'b1, 16'h9696, 16'h0000, "hold_after_reset");

        // Load, then hold while mode and in wiggle.
        step(1'b0, 1'b1, 1'b1, 16'h9696, 16'h9696, "load_9696");
        step(1'b0, 1'b0, 1'b1, 16'h5555, 16'h9696, "hold_load_mode1");
        step(1'b0, 1'b0, 1'b0, 16'h0F0F, 16'h9696, "hold_load_mode0");

        // Negative value shifts in sign bits.
        step(1'b0, 1'b1, 1'b0, 16'h0000, 16'hCB4B, "neg_shift1");
        step(1'b0, 1'b1, 1'b0, 16'h0000, 16'hE5A5, "neg_shift2");
        step(1'b0, 1'b1, 1'b0, 16'h0000, 16'hF2D2, "neg_shift3");

        // Positive value shifts in zeros and decays.
        step(1'b0, 1'b1, 1'b1, 16'h4B4B, 16'h4B4B, "load_4b4b");
        step(1'b0, 1'b1, 1'b0, 16'hFFFF, 16'h25A5, "pos_shift1");
        step(1'b0, 1'b1, 1'b0, 16'hFFFF, 16'h12D2, "pos_shift2");
        step(1'b0, 1'b1, 1'b1, 16'h0001, 16'h0001, "load_0001");
        step(1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, "lsb_discard");
        step(1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, "zero_stays_zero");

        // Most negative value saturates to all ones in WIDTH-1 shifts.
        step(1'b0, 1'b1, 1'b1, 16'h8000, 16'h8000, "load_8000");
        for (int i = 0; i < 15; i++)
            step(1'b0, 1'b1, 1'b0, 16'h0000, sat_tab[i], "sat_shift");
        step(1'b0, 1'b1, 1'b0, 16'h0000, 16'hFFFF, "all_ones_stays");

        // Reset in the middle of a shift sequence.
        step(1'b0, 1'b1, 1'b1, 16'h9696, 16'h9696, "load_mid");
        step(1'b0, 1'b1, 1'b0, 16'h0000, 16'hCB4B, "shift_mid");
        step(1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, "reset_mid");
        step(1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, "shift_after_reset");

        // Reset wins over a simultaneous load; load lands once reset drops.
        step(1'b0, 1'b1, 1'b1, 16'h7777, 16'h7777, "preload_7777");
        step(1'b1, 1'b1, 1'b1, 16'hAAAA, 16'h0000, "reset_priority");
        step(1'b0, 1'b1, 1'b1, 16'hAAAA, 16'hAAAA, "load_after_reset");
        step(1'b0, 1'b0, 1'b0, 16'h0000, 16'hAAAA, "final_hold");

        waited = 0;
        while (exp_q.size() > 0 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (exp_q.size() > 0) begin
            n_bad++;
            $display("FAIL drain: pending=%0d expected=0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
